// File: rtl/mbist_pkg.sv
// Shared MBIST types and default widths for the multiplexer, controller and response analyzer.
package mbist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } mbist_state_e;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefAddrWidth = 6;
    localparam int unsigned DefRdLatency = 1;
    localparam int unsigned DefCntWidth  = 8;

endpackage

// File: rtl/mbist_delay_line.sv
// Shift register carrying {valid, expected data, address} alongside the memory read latency.
module mbist_delay_line #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [DEPTH-1:0]      valid_q;
    logic [WIDTH-1:0]      data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            // Flush only kills the valid bits; stale payload is never looked at.
            if (flush_i) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= valid_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
            data_q[0] <= data_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data_q[i] <= data_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/mbist_response_analyzer.sv
// Read-side MBIST checker: compares memory data against delayed expected data and logs failures.
// Define MBIST_FAIL_LOG_EN to capture the address and data of the first mismatch.
module mbist_response_analyzer
    import mbist_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned RD_LATENCY = DefRdLatency,
    parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  NbarT,
    input  logic                  start,
    input  logic                  end_test,
    input  logic                  rd_en,
    input  logic [WIDTH-1:0]      exp_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WIDTH-1:0]      mem_q,
    output logic [WIDTH-1:0]      normal_q,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0]      fail_data
);

    localparam int unsigned DrainW = $clog2(RD_LATENCY + 1);

    mbist_state_e          state_q, state_d;
    logic [DrainW-1:0]     drain_q, drain_d;
    logic                  flush, clear, enq, mism;
    logic                  head_valid;
    logic [WIDTH-1:0]      head_data;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [CNT_WIDTH-1:0]  err_q;
    logic                  fail_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        flush   = 1'b0;
        clear   = 1'b0;
        if (!NbarT) begin
            state_d = StIdle;
            flush   = 1'b1;
        end else if (start) begin
            state_d = StRun;
            flush   = 1'b1;
            clear   = 1'b1;
        end else begin
            case (state_q)
                StRun: begin
                    if (end_test) begin
                        state_d = StDrain;
                        drain_d = DrainW'(RD_LATENCY);
                    end
                end
                StDrain: begin
                    drain_d = drain_q - DrainW'(1);
                    if (drain_d == '0) state_d = StDone;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // A read issued in the same cycle as a restart or mode drop is discarded.
    assign enq = (state_q == StRun) && rd_en && NbarT && !start;

    mbist_delay_line #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (RD_LATENCY)
    ) u_delay_line (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .valid_i (enq),
        .data_i  (exp_data),
        .addr_i  (rd_addr),
        .valid_o (head_valid),
        .data_o  (head_data),
        .addr_o  (head_addr)
    );

    assign mism = head_valid && NbarT && !start && (head_data != mem_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= '0;
            fail_q <= 1'b0;
        end else if (clear) begin
            err_q  <= '0;
            fail_q <= 1'b0;
        end else if (mism) begin
            if (err_q != {CNT_WIDTH{1'b1}}) err_q <= err_q + CNT_WIDTH'(1);
            fail_q <= 1'b1;
        end
    end

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [WIDTH-1:0]      fail_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (clear) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (mism && !fail_q) begin
            fail_addr_q <= head_addr;
            fail_data_q <= mem_q;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    logic unused_head_addr;
    assign unused_head_addr = ^head_addr;
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

    assign normal_q  = NbarT ? '0 : mem_q;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign fail      = fail_q;
    assign pass      = done && !fail_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_mbist_response_analyzer.sv
// Directed self-checking bench for mbist_response_analyzer (WIDTH=8, RD_LATENCY=1).
module tb_mbist_response_analyzer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       NbarT = 1'b0;
    logic       start = 1'b0;
    logic       end_test = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] mem_q = 8'h00;
    logic [7:0] normal_q;
    logic       busy, done, pass, fail;
    logic [7:0] err_count;
    logic [5:0] fail_addr;
    logic [7:0] fail_data;

    int n_tests = 0;
    int n_fail  = 0;

    mbist_response_analyzer #(
        .WIDTH      (8),
        .ADDR_WIDTH (6),
        .RD_LATENCY (1),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .NbarT     (NbarT),
        .start     (start),
        .end_test  (end_test),
        .rd_en     (rd_en),
        .exp_data  (exp_data),
        .rd_addr   (rd_addr),
        .mem_q     (mem_q),
        .normal_q  (normal_q),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Four reads at addr 0..3 expecting 0x55; memory returns m[i] one cycle later.
    task automatic run4(input logic [7:0] m0, input logic [7:0] m1,
                        input logic [7:0] m2, input logic [7:0] m3);
        logic [7:0] m [4];
        logic       early_fail;
        m = '{m0, m1, m2, m3};
        early_fail = (m0 != 8'h55) || (m1 != 8'h55) || (m2 != 8'h55);
        for (int i = 0; i < 4; i++) begin
            rd_en    = 1'b1;
            rd_addr  = 6'(i);
            exp_data = 8'h55;
            mem_q    = (i == 0) ? 8'h00 : m[i-1];
            end_test = (i == 3);
            cycle();
        end
        check_eq("drain_fail_after_addr2", {31'd0, fail}, {31'd0, early_fail});
        check_eq("drain_busy", {31'd0, busy}, 32'd1);
        check_eq("drain_done", {31'd0, done}, 32'd0);
        rd_en    = 1'b0;
        end_test = 1'b0;
        mem_q    = m[3];
        cycle();
        mem_q    = 8'h00;
    endtask

    initial begin
        // Normal mode and reset values
        mem_q = 8'hA5;
        #3;
        check_eq("rst_normal_q", {24'd0, normal_q}, 32'hA5);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {24'd0, err_count}, 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("normal_q_pass", {24'd0, normal_q}, 32'hA5);
        NbarT = 1'b1;
        #1;
        check_eq("normal_q_test", {24'd0, normal_q}, 32'h00);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Clean run
        pulse_start();
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        check_eq("start_err", {24'd0, err_count}, 32'd0);
        run4(8'h55, 8'h55, 8'h55, 8'h55);
        check_eq("clean_done", {31'd0, done}, 32'd1);
        check_eq("clean_pass", {31'd0, pass}, 32'd1);
        check_eq("clean_fail", {31'd0, fail}, 32'd0);
        check_eq("clean_err", {24'd0, err_count}, 32'd0);

        // Mismatch logging
        pulse_start();
        run4(8'h55, 8'h55, 8'h54, 8'h00);
        check_eq("mis_done", {31'd0, done}, 32'd1);
        check_eq("mis_pass", {31'd0, pass}, 32'd0);
        check_eq("mis_fail", {31'd0, fail}, 32'd1);
        check_eq("mis_err", {24'd0, err_count}, 32'd2);
`ifdef MBIST_FAIL_LOG_EN
        check_eq("mis_fail_addr", {26'd0, fail_addr}, 32'd2);
        check_eq("mis_fail_data", {24'd0, fail_data}, 32'h54);
`else
        check_eq("mis_fail_addr", {26'd0, fail_addr}, 32'd0);
        check_eq("mis_fail_data", {24'd0, fail_data}, 32'h00);
`endif
        cycle();
        check_eq("done_holds", {31'd0, done}, 32'd1);

        // Saturation: 300 mismatched reads
        pulse_start();
        check_eq("restart_err", {24'd0, err_count}, 32'd0);
        check_eq("restart_fail", {31'd0, fail}, 32'd0);
        exp_data = 8'h00;
        mem_q    = 8'hFF;
        rd_addr  = 6'd5;
        rd_en    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            end_test = (i == 299);
            cycle();
        end
        rd_en    = 1'b0;
        end_test = 1'b0;
        cycle();
        check_eq("sat_done", {31'd0, done}, 32'd1);
        check_eq("sat_err", {24'd0, err_count}, 32'hFF);
`ifdef MBIST_FAIL_LOG_EN
        check_eq("sat_fail_addr", {26'd0, fail_addr}, 32'd5);
`endif
        cycle();
        cycle();
        check_eq("sat_err_hold", {24'd0, err_count}, 32'hFF);
        pulse_start();
        check_eq("sat_clear", {24'd0, err_count}, 32'h00);

        // Mode drop mid-run
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        cycle();
        check_eq("drop_pre_err", {24'd0, err_count}, 32'd1);
        check_eq("drop_pre_busy", {31'd0, busy}, 32'd1);
        NbarT = 1'b0;
        rd_en = 1'b1;
        cycle();
        check_eq("drop_busy", {31'd0, busy}, 32'd0);
        check_eq("drop_done", {31'd0, done}, 32'd0);
        check_eq("drop_normal_q", {24'd0, normal_q}, 32'hFF);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        rd_en = 1'b0;
        check_eq("drop_err_held", {24'd0, err_count}, 32'd1);
        check_eq("drop_fail_held", {31'd0, fail}, 32'd1);
        check_eq("drop_start_ignored", {31'd0, busy}, 32'd0);

        // Async reset mid-DRAIN
        NbarT = 1'b1;
        pulse_start();
        rd_en = 1'b1;
        cycle();
        end_test = 1'b1;
        cycle();
        rd_en    = 1'b0;
        end_test = 1'b0;
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        check_eq("pre_rst_err", {24'd0, err_count}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_fail", {31'd0, fail}, 32'd0);
        check_eq("arst_err", {24'd0, err_count}, 32'd0);
        cycle();
        rst   = 1'b0;
        rd_en = 1'b1;
        cycle();
        cycle();
        cycle();
        rd_en = 1'b0;
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("post_rst_done", {31'd0, done}, 32'd0);
        check_eq("post_rst_err", {24'd0, err_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_response_analyzer.md
# mbist_response_analyzer

Read-side counterpart to the BIST input multiplexer: sits on the memory read-data path. In normal mode (NbarT=0) it routes memory read data to the functional logic. In test mode (NbarT=1) it compares read data against the controller's expected pattern, counts mismatches and reports pass/fail. Expected data and address are pipelined internally to align with the memory's read latency.

## Interface
Parameters:
- WIDTH, 8, data width; must match the write-side multiplexer.
- ADDR_WIDTH, 6, address width.
- RD_LATENCY, 1, cycles from a read issue to valid data on mem_q; minimum 1.
- CNT_WIDTH, 8, error-counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- NbarT  in  1  mode select: 0 = normal, 1 = BIST.
- start  in  1  one-cycle pulse; clears results and begins a run.
- end_test  in  1  one-cycle pulse; the controller has issued its last read.
- rd_en  in  1  a BIST read is issued this cycle.
- exp_data  in  WIDTH  expected read data, aligned with rd_en.
- rd_addr  in  ADDR_WIDTH  read address, aligned with rd_en.
- mem_q  in  WIDTH  memory read data, valid RD_LATENCY cycles after rd_en.
- normal_q  out  WIDTH  combinational; equals mem_q when NbarT=0, 0 when NbarT=1.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done & ~fail.
- fail  out  1  sticky; set on the first mismatch.
- err_count  out  CNT_WIDTH  mismatch count; saturates at all-ones.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_data  out  WIDTH  mem_q value captured at the first mismatch.

## Operation
FSM states are IDLE, RUN, DRAIN and DONE.

State transitions:
- IDLE/DONE -> RUN on start with NbarT=1.
- RUN -> DRAIN on end_test. The drain counter loads RD_LATENCY.
- DRAIN -> DONE when the drain counter reaches 0.
- start while in RUN, DRAIN or DONE with NbarT=1 restarts: results clear, the pipeline flushes, next state is RUN.
- NbarT=0 in any state -> IDLE on the next edge. The pipeline flushes, and err_count, fail and the log are held.
- start is ignored while NbarT=0.

Read tracking:
- A read is enqueued only in RUN, when rd_en=1. rd_en in IDLE, DRAIN or DONE is dropped.
- rd_en together with end_test in the same cycle: the read is enqueued, then the FSM goes to DRAIN.
- After RD_LATENCY cycles the delay-line head is compared with mem_q. A mismatch is any bit difference (exp_data != mem_q).

On a mismatch:
- err_count increments, saturating at all-ones.
- fail sets.
- If this is the first mismatch since start, fail_addr and fail_data are captured.

start clears err_count, fail, fail_addr and fail_data to 0.

## Timing
- Reset: all outputs read 0 and the state is IDLE, effective immediately on rst without waiting for an edge. normal_q follows mem_q/NbarT combinationally, even during reset.
- A read sampled at edge k is compared at edge k+RD_LATENCY. fail, err_count and the log are visible after that edge.
- end_test sampled at edge e: DONE and the final pass/fail become valid after edge e+RD_LATENCY. The last read's compare and the DRAIN->DONE transition happen on the same edge.
- start sampled at edge s: busy=1 and results read 0 after edge s.
- done holds until start, NbarT=0 or rst.

## Configuration
- MBIST_FAIL_LOG_EN defined: fail_addr and fail_data capture the first mismatch as specified above.
- Undefined: no capture registers exist, and fail_addr and fail_data are tied to 0. err_count and pass/fail are unchanged.

## Structure
- mbist_pkg holds:
  - the FSM state enum typedef (IDLE, RUN, DRAIN, DONE);
  - default-width localparams shared with the multiplexer and controller.
- Sub-module mbist_delay_line: an RD_LATENCY-deep shift register of {valid, exp_data, rd_addr}. It has a synchronous flush input driven on start or NbarT=0.

## Test plan
All scenarios use WIDTH=8, ADDR_WIDTH=6, RD_LATENCY=1, CNT_WIDTH=8.

- Normal mode: rst pulse, NbarT=0, mem_q=0xA5 -> normal_q=0xA5, busy=0, done=0, err_count=0. Set NbarT=1 -> normal_q=0x00.
- Clean run: start, then reads at addr 0..3 with exp_data=0x55 and mem_q=0x55 one cycle later; end_test with the read at addr 3 -> done=1 one edge after end_test, pass=1, fail=0, err_count=0.
- Mismatch logging: as above, but mem_q=0x54 for addr 2 and 0x00 for addr 3 -> fail=1 after the addr-2 compare edge; final err_count=2, fail_addr=2, fail_data=0x54, pass=0. Without MBIST_FAIL_LOG_EN: fail_addr=0, fail_data=0, err_count=2.
- Saturation: 300 consecutive mismatched reads -> err_count=0xFF and holds; the next start -> err_count=0x00.
- Mode drop mid-run: NbarT 1->0 in RUN after 1 mismatch -> IDLE next edge, busy=0, done=0, err_count=1 held; reads presented while NbarT=0 are not counted.
- Async reset mid-DRAIN: assert rst between edges -> busy, done, fail and err_count read 0 immediately; after release, with no start, the state stays IDLE.
